btb_assoc: RTL and testbench

Parametrised two-way set-associative branch target buffer with partial tags, per-entry valid bits, 2-bit saturating direction counters and per-set LRU replacement. It sits beside the IF stage: fetch presents its PC and gets a same-cycle hit, direction and target. The resolving stage writes branch outcomes back. A global flush supports context switches and self-modifying code.

---
 rtl/btb_assoc_pkg.sv | 29 ++
 rtl/btb_assoc_if.sv | 27 ++
 rtl/btb_assoc_way.sv | 77 +++++++
 rtl/btb_assoc.sv | 130 +++++++++++++
 tb/tb_btb_assoc.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/btb_assoc_pkg.sv
// Shared types and helpers for the two-way branch target buffer.
// Counter encoding, allocation value and saturating counter arithmetic.
package btb_pkg;

    localparam logic [1:0] CNT_SNT   = 2'b00;
    localparam logic [1:0] CNT_WNT   = 2'b01;
    localparam logic [1:0] CNT_WT    = 2'b10;
    localparam logic [1:0] CNT_ST    = 2'b11;
    localparam logic [1:0] CNT_ALLOC = CNT_WT;

    localparam int unsigned ENTRY_TAG_W  = 10;
    localparam int unsigned ENTRY_ADDR_W = 32;

    typedef struct packed {
        logic                    valid;
        logic [ENTRY_TAG_W-1:0]  tag;
        logic [ENTRY_ADDR_W-1:0] target;
        logic [1:0]              cnt;
    } btb_entry_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == CNT_ST) ? CNT_ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == CNT_SNT) ? CNT_SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch-lookup and resolve-update bus of the branch target buffer.
// master drives lookups/updates, slave is the BTB itself.
interface btb_assoc_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              lookup_en;
    logic [ADDR_W-1:0] lookup_pc;
    logic              hit;
    logic              predict_taken;
    logic [ADDR_W-1:0] predict_target;
    logic [1:0]        counter_state;
    logic              upd_en;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              flush;

    modport master (
        output lookup_en, lookup_pc, upd_en, upd_pc, upd_taken, upd_target, flush,
        input  hit, predict_taken, predict_target, counter_state
    );

    modport slave (
        input  lookup_en, lookup_pc, upd_en, upd_pc, upd_taken, upd_target, flush,
        output hit, predict_taken, predict_target, counter_state
    );
endinterface

// File: rtl/btb_assoc_way.sv
// Storage for one BTB way: combinational lookup read port, plus a write port that
// also exposes the current valid/tag/counter of the written set for read-modify-write.
module btb_way
    import btb_pkg::*;
#(
    parameter  int unsigned SETS   = 32,
    parameter  int unsigned TAG_W  = 10,
    parameter  int unsigned ADDR_W = 32,
    localparam int unsigned IDX_W  = $clog2(SETS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [ADDR_W-1:0] o_rd_target,
    output logic [1:0]        o_rd_cnt,
    input  logic [IDX_W-1:0]  i_wr_idx,
    output logic              o_wr_valid,
    output logic [TAG_W-1:0]  o_wr_tag,
    output logic [1:0]        o_wr_cnt,
    input  logic              i_wr_valid_en,
    input  logic              i_wr_tag_en,
    input  logic              i_wr_target_en,
    input  logic              i_wr_cnt_en,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [ADDR_W-1:0] i_wr_target,
    input  logic [1:0]        i_wr_cnt,
    input  logic              i_clr_valid
);

    logic [SETS-1:0]   r_valid;
    logic [1:0]        r_cnt    [SETS];
    logic [TAG_W-1:0]  r_tag    [SETS];
    logic [ADDR_W-1:0] r_target [SETS];

    always_comb begin
        o_rd_valid  = r_valid[i_rd_idx];
        o_rd_tag    = r_tag[i_rd_idx];
        o_rd_target = r_target[i_rd_idx];
        o_rd_cnt    = r_cnt[i_rd_idx];
        o_wr_valid  = r_valid[i_wr_idx];
        o_wr_tag    = r_tag[i_wr_idx];
        o_wr_cnt    = r_cnt[i_wr_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (i_clr_valid) begin
            r_valid <= '0;
        end else if (i_wr_valid_en) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SETS); i++) begin
                r_cnt[i] <= CNT_SNT;
            end
        end else if (i_wr_cnt_en && !i_clr_valid) begin
            r_cnt[i_wr_idx] <= i_wr_cnt;
        end
    end

    // Tags and targets are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (i_wr_tag_en && !i_clr_valid) begin
            r_tag[i_wr_idx] <= i_wr_tag;
        end
        if (i_wr_target_en && !i_clr_valid) begin
            r_target[i_wr_idx] <= i_wr_target;
        end
    end

endmodule

// File: rtl/btb_assoc.sv
// Two-way set-associative BTB with partial tags, 2-bit counters and per-set LRU.
// Lookup is combinational from stored state; updates and flush commit at the clock edge.
module btb_assoc
    import btb_pkg::*;
#(
    parameter int unsigned SETS   = 32,
    parameter int unsigned TAG_W  = 10,
    parameter int unsigned ADDR_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    btb_assoc_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(SETS);

    logic [IDX_W-1:0]  w_lk_idx;
    logic [TAG_W-1:0]  w_lk_tag;
    logic [IDX_W-1:0]  w_upd_idx;
    logic [TAG_W-1:0]  w_upd_tag;

    logic [1:0]        w_lk_valid;
    logic [TAG_W-1:0]  w_lk_tag_q    [2];
    logic [ADDR_W-1:0] w_lk_target_q [2];
    logic [1:0]        w_lk_cnt_q    [2];
    logic [1:0]        w_u_valid;
    logic [TAG_W-1:0]  w_u_tag_q     [2];
    logic [1:0]        w_u_cnt_q     [2];

    logic [1:0]        w_lk_hit;
    logic              w_lk_way;
    logic [1:0]        w_u_hit;
    logic              w_u_hit_any;
    logic              w_victim;
    logic              w_sel;
    logic              w_alloc;
    logic              w_do_upd;
    logic [1:0]        w_new_cnt;
    logic [1:0]        w_wr_en;
    logic              w_unused_pc;

    logic [SETS-1:0]   r_lru;

    assign w_lk_idx    = bus.lookup_pc[IDX_W+1:2];
    assign w_lk_tag    = bus.lookup_pc[IDX_W+1+TAG_W:IDX_W+2];
    assign w_upd_idx   = bus.upd_pc[IDX_W+1:2];
    assign w_upd_tag   = bus.upd_pc[IDX_W+1+TAG_W:IDX_W+2];
    assign w_unused_pc = ^{bus.lookup_pc, bus.upd_pc};

    for (genvar g = 0; g < 2; g++) begin : g_way
        btb_way #(
            .SETS   (SETS),
            .TAG_W  (TAG_W),
            .ADDR_W (ADDR_W)
        ) u_way (
            .clk            (clk),
            .reset_n        (reset_n),
            .i_rd_idx       (w_lk_idx),
            .o_rd_valid     (w_lk_valid[g]),
            .o_rd_tag       (w_lk_tag_q[g]),
            .o_rd_target    (w_lk_target_q[g]),
            .o_rd_cnt       (w_lk_cnt_q[g]),
            .i_wr_idx       (w_upd_idx),
            .o_wr_valid     (w_u_valid[g]),
            .o_wr_tag       (w_u_tag_q[g]),
            .o_wr_cnt       (w_u_cnt_q[g]),
            .i_wr_valid_en  (w_wr_en[g] && w_alloc),
            .i_wr_tag_en    (w_wr_en[g] && w_alloc),
            .i_wr_target_en (w_wr_en[g] && bus.upd_taken),
            .i_wr_cnt_en    (w_wr_en[g]),
            .i_wr_tag       (w_upd_tag),
            .i_wr_target    (bus.upd_target),
            .i_wr_cnt       (w_new_cnt),
            .i_clr_valid    (bus.flush)
        );
    end

    // Lookup side: way 0 wins if both ways match.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            w_lk_hit[g] = bus.lookup_en && w_lk_valid[g] && (w_lk_tag_q[g] == w_lk_tag);
        end
        w_lk_way = !w_lk_hit[0];
        bus.hit            = |w_lk_hit;
        bus.predict_target = '0;
        bus.counter_state  = CNT_SNT;
        if (|w_lk_hit) begin
            bus.predict_target = w_lk_target_q[w_lk_way];
            bus.counter_state  = w_lk_cnt_q[w_lk_way];
        end
        bus.predict_taken = bus.hit && bus.counter_state[1];
    end

    // Update side: hit way, else first invalid way, else the LRU way.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            w_u_hit[g] = w_u_valid[g] && (w_u_tag_q[g] == w_upd_tag);
        end
        w_u_hit_any = |w_u_hit;
        if (!w_u_valid[0]) begin
            w_victim = 1'b0;
        end else if (!w_u_valid[1]) begin
            w_victim = 1'b1;
        end else begin
            w_victim = r_lru[w_upd_idx];
        end
        w_sel    = w_u_hit_any ? !w_u_hit[0] : w_victim;
        w_alloc  = !w_u_hit_any && bus.upd_taken;
        w_do_upd = bus.upd_en && !bus.flush && (w_u_hit_any || bus.upd_taken);
        if (!w_u_hit_any) begin
            w_new_cnt = CNT_ALLOC;
        end else if (bus.upd_taken) begin
            w_new_cnt = sat_inc(w_u_cnt_q[w_sel]);
        end else begin
            w_new_cnt = sat_dec(w_u_cnt_q[w_sel]);
        end
        w_wr_en = w_do_upd ? {w_sel, !w_sel} : 2'b00;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lru <= '0;
        end else if (bus.flush) begin
            r_lru <= '0;
        end else if (w_do_upd) begin
            r_lru[w_upd_idx] <= !w_sel;
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed self-checking bench for btb_assoc (SETS=32, TAG_W=10, ADDR_W=32).
// Stimulus is applied 1 time unit after the rising edge; outputs are sampled shortly after.
module tb_btb_assoc;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    btb_assoc_if #(.ADDR_W(32)) u_bus ();

    btb_assoc #(
        .SETS   (32),
        .TAG_W  (10),
        .ADDR_W (32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (u_bus)
    );

    always #5 clk = ~clk;

    task automatic idle_bus();
        u_bus.lookup_en  = 1'b0;
        u_bus.lookup_pc  = '0;
        u_bus.upd_en     = 1'b0;
        u_bus.upd_pc     = '0;
        u_bus.upd_taken  = 1'b0;
        u_bus.upd_target = '0;
        u_bus.flush      = 1'b0;
    endtask

    // One update across one rising edge; returns 1 unit after that edge.
    task automatic upd_cycle(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        u_bus.upd_en     = 1'b1;
        u_bus.upd_pc     = pc;
        u_bus.upd_taken  = taken;
        u_bus.upd_target = tgt;
        @(posedge clk);
        #1;
        u_bus.upd_en = 1'b0;
    endtask

    task automatic flush_cycle();
        u_bus.flush = 1'b1;
        @(posedge clk);
        #1;
        u_bus.flush = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        u_bus.lookup_en = 1'b1;
        u_bus.lookup_pc = pc;
        #1;
    endtask

    task automatic test_reset();
        idle_bus();
        reset_n = 1'b0;
        look(32'h40);
        n_checks++;
        if (u_bus.hit !== 1'b0 || u_bus.predict_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: hit=%b taken=%b, expected 0 0", u_bus.hit,
                     u_bus.predict_taken);
        end
        n_checks++;
        if (u_bus.predict_target !== 32'h0 || u_bus.counter_state !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_values: target=%h cnt=%b, expected 0 00",
                     u_bus.predict_target, u_bus.counter_state);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_allocate();
        flush_cycle();
        upd_cycle(32'h40, 1'b1, 32'h100);
        look(32'h40);
        n_checks++;
        if (u_bus.hit !== 1'b1 || u_bus.predict_taken !== 1'b1 ||
            u_bus.predict_target !== 32'h100 || u_bus.counter_state !== 2'b10) begin
            n_fail++;
            $display("FAIL alloc_hit: hit=%b taken=%b tgt=%h cnt=%b, expected 1 1 00000100 10",
                     u_bus.hit, u_bus.predict_taken, u_bus.predict_target, u_bus.counter_state);
        end
        look(32'h44);
        n_checks++;
        if (u_bus.hit !== 1'b0) begin
            n_fail++;
            $display("FAIL alloc_other_set: hit=%b, expected 0", u_bus.hit);
        end
    endtask

    task automatic test_saturation();
        logic       dirs [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [1:0] exp  [7] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
        // Entry 0x40 is at counter 10 from the allocate test.
        for (int i = 0; i < 7; i++) begin
            upd_cycle(32'h40, dirs[i], 32'h100);
            look(32'h40);
            n_checks++;
            if (u_bus.hit !== 1'b1 || u_bus.counter_state !== exp[i] ||
                u_bus.predict_taken !== exp[i][1]) begin
                n_fail++;
                $display("FAIL saturation_%0d: hit=%b cnt=%b taken=%b, expected 1 %b %b", i,
                         u_bus.hit, u_bus.counter_state, u_bus.predict_taken, exp[i], exp[i][1]);
            end
        end
    endtask

    task automatic test_lru_evict();
        flush_cycle();
        upd_cycle(32'h40, 1'b1, 32'h100);
        upd_cycle(32'hC0, 1'b1, 32'h180);
        upd_cycle(32'h40, 1'b0, 32'h0);
        upd_cycle(32'h140, 1'b1, 32'h200);
        look(32'hC0);
        n_checks++;
        if (u_bus.hit !== 1'b0) begin
            n_fail++;
            $display("FAIL lru_victim_gone: hit=%b, expected 0", u_bus.hit);
        end
        look(32'h40);
        n_checks++;
        if (u_bus.hit !== 1'b1 || u_bus.counter_state !== 2'b01 ||
            u_bus.predict_target !== 32'h100) begin
            n_fail++;
            $display("FAIL lru_keep_mru: hit=%b cnt=%b tgt=%h, expected 1 01 00000100",
                     u_bus.hit, u_bus.counter_state, u_bus.predict_target);
        end
        look(32'h140);
        n_checks++;
        if (u_bus.hit !== 1'b1 || u_bus.predict_target !== 32'h200 ||
            u_bus.counter_state !== 2'b10) begin
            n_fail++;
            $display("FAIL lru_new_entry: hit=%b tgt=%h cnt=%b, expected 1 00000200 10",
                     u_bus.hit, u_bus.predict_target, u_bus.counter_state);
        end
    endtask

    task automatic test_no_alloc();
        flush_cycle();
        upd_cycle(32'h80, 1'b0, 32'h0);
        look(32'h80);
        n_checks++;
        if (u_bus.hit !== 1'b0) begin
            n_fail++;
            $display("FAIL no_alloc_nt: hit=%b, expected 0", u_bus.hit);
        end
        // Same-cycle lookup sees pre-update contents.
        u_bus.upd_en     = 1'b1;
        u_bus.upd_pc     = 32'h80;
        u_bus.upd_taken  = 1'b1;
        u_bus.upd_target = 32'h300;
        #1;
        n_checks++;
        if (u_bus.hit !== 1'b0) begin
            n_fail++;
            $display("FAIL no_bypass: hit=%b, expected 0", u_bus.hit);
        end
        @(posedge clk);
        #1;
        u_bus.upd_en = 1'b0;
        #1;
        n_checks++;
        if (u_bus.hit !== 1'b1 || u_bus.predict_target !== 32'h300) begin
            n_fail++;
            $display("FAIL after_alloc: hit=%b tgt=%h, expected 1 00000300", u_bus.hit,
                     u_bus.predict_target);
        end
    endtask

    task automatic test_flush_priority();
        flush_cycle();
        upd_cycle(32'h40, 1'b1, 32'h100);
        u_bus.flush = 1'b1;
        upd_cycle(32'hC0, 1'b1, 32'h180);
        u_bus.flush = 1'b0;
        look(32'h40);
        n_checks++;
        if (u_bus.hit !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clears: hit=%b, expected 0", u_bus.hit);
        end
        look(32'hC0);
        n_checks++;
        if (u_bus.hit !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_drops_upd: hit=%b, expected 0", u_bus.hit);
        end
    endtask

    task automatic test_back_to_back();
        flush_cycle();
        upd_cycle(32'h140, 1'b1, 32'h240);
        upd_cycle(32'h140, 1'b0, 32'h0);
        upd_cycle(32'h140, 1'b0, 32'h0);
        upd_cycle(32'h140, 1'b1, 32'h280);
        look(32'h140);
        n_checks++;
        if (u_bus.hit !== 1'b1 || u_bus.counter_state !== 2'b01 ||
            u_bus.predict_taken !== 1'b0 || u_bus.predict_target !== 32'h280) begin
            n_fail++;
            $display("FAIL back_to_back: hit=%b cnt=%b taken=%b tgt=%h, expected 1 01 0 00000280",
                     u_bus.hit, u_bus.counter_state, u_bus.predict_taken, u_bus.predict_target);
        end
    endtask

    task automatic test_reset_midrun();
        flush_cycle();
        upd_cycle(32'h40, 1'b1, 32'h100);
        look(32'h40);
        n_checks++;
        if (u_bus.hit !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_hit: hit=%b, expected 1", u_bus.hit);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (u_bus.hit !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: hit=%b, expected 0", u_bus.hit);
        end
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (u_bus.hit !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset: hit=%b, expected 0", u_bus.hit);
        end
        upd_cycle(32'h40, 1'b1, 32'h120);
        u_bus.lookup_en = 1'b0;
        #1;
        n_checks++;
        if (u_bus.hit !== 1'b0 || u_bus.predict_target !== 32'h0 ||
            u_bus.counter_state !== 2'b00 || u_bus.predict_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL lookup_disabled: hit=%b tgt=%h cnt=%b taken=%b, expected 0 0 00 0",
                     u_bus.hit, u_bus.predict_target, u_bus.counter_state, u_bus.predict_taken);
        end
        look(32'h40);
        n_checks++;
        if (u_bus.hit !== 1'b1 || u_bus.predict_target !== 32'h120) begin
            n_fail++;
            $display("FAIL first_upd_after_reset: hit=%b tgt=%h, expected 1 00000120",
                     u_bus.hit, u_bus.predict_target);
        end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_saturation();
        test_lru_evict();
        test_no_alloc();
        test_flush_priority();
        test_back_to_back();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
